ann_layer_sequencer: RTL and testbench

Control FSM sitting directly upstream of the ANN datapath; replaces hand-sequenced stimulus with a fixed schedule.
- On start, it reads the input vector and per-neuron weights from external synchronous memories.
- It drives the ANN control strobes and `in` bus through input load, 10 neuron MAC slots, bias, ReLU and max-function load.
- It raises done when the layer is complete.

---
 rtl/ann_pkg.sv | 60 ++++++
 rtl/ann_layer_sequencer_if.sv | 53 +++++
 rtl/ann_seq_addr_gen.sv | 51 +++++
 rtl/ann_layer_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_ann_layer_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ann_pkg.sv
// ============================================================================
// Module : ann_pkg
// Brief  : Shared types and slot-timing constants for the ANN layer sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ann_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE     = 3'd1,
        S_LOAD_IN = 3'd2,
        S_GAP     = 3'd3,
        S_NEURON  = 3'd4,
        S_MAX     = 3'd5,
        S_DONE    = 3'd6
    } seq_state_t;

    // Source of the `in` bus for the current cycle
    typedef enum logic [1:0] {
        SRC_HOLD   = 2'd0,
        SRC_MEM    = 2'd1,
        SRC_BIAS_L = 2'd2,
        SRC_BIAS_H = 2'd3
    } in_src_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ld_in;
        logic       ld_weight;
        logic       shift_in;
        logic       change;
        logic       ld_multiplication;
        logic       ld_bias_lsb;
        logic       ld_bias_msb;
        logic       bias_addition;
        logic       relu;
        logic       rst_sum;
        logic       ld_max_func;
        logic [3:0] neuron;
    } ann_ctl_t;

    localparam logic [3:0] MEM_SEL_INPUT = 4'hF;

    // Slot offsets for the default input count; the sequencer rebases them
    // on its own N_INPUTS, since only the tail after the MAC phase is fixed.
    localparam int DEF_N_INPUTS = 32;
    localparam int T_CHANGE     = 2*DEF_N_INPUTS + 1;
    localparam int T_BIAS_L     = T_CHANGE + 1;
    localparam int T_BIAS_H     = T_CHANGE + 2;
    localparam int T_BADD       = T_CHANGE + 3;
    localparam int T_RELU       = T_CHANGE + 5;
    localparam int T_RSUM       = T_CHANGE + 6;
    localparam int SLOT_LEN     = T_CHANGE + 7;

endpackage

`default_nettype wire

// File: rtl/ann_layer_sequencer_if.sv
// ============================================================================
// Module : ann_seq_if
// Brief  : Memory, control and ANN strobe bundle of the layer sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ann_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic                  start;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  mem_rd_en;
    logic [3:0]            mem_sel;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_rdata;
    logic [3:0]            bias_addr;
    logic [2*DATA_W-1:0]   bias_rdata;
    logic [DATA_W-1:0]     in;
    logic                  ld_in;
    logic                  ld_weight;
    logic                  shift_in;
    logic                  change;
    logic                  ld_multiplication;
    logic                  ld_bias_LSB;
    logic                  ld_bias_MSB;
    logic                  bias_addition;
    logic                  ReLU_computation;
    logic                  rst_sum;
    logic                  ld_max_func;
    logic [3:0]            ld_neuron;

    modport master (
        input  start, abort, mem_rdata, bias_rdata,
        output busy, done, mem_rd_en, mem_sel, mem_addr, bias_addr, in,
               ld_in, ld_weight, shift_in, change, ld_multiplication,
               ld_bias_LSB, ld_bias_MSB, bias_addition, ReLU_computation,
               rst_sum, ld_max_func, ld_neuron
    );

    modport slave (
        output start, abort, mem_rdata, bias_rdata,
        input  busy, done, mem_rd_en, mem_sel, mem_addr, bias_addr, in,
               ld_in, ld_weight, shift_in, change, ld_multiplication,
               ld_bias_LSB, ld_bias_MSB, bias_addition, ReLU_computation,
               rst_sum, ld_max_func, ld_neuron
    );
endinterface

`default_nettype wire

// File: rtl/ann_seq_addr_gen.sv
// ============================================================================
// Module : ann_seq_addr_gen
// Brief  : Registered memory read port; issues reads one cycle ahead of use.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ann_seq_addr_gen #(
    parameter int N_INPUTS = 32,
    parameter int ADDR_W   = 5
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              issue,
    input  wire logic              restart,
    input  wire logic [3:0]        bank,
    output logic                   mem_rd_en,
    output logic [3:0]             mem_sel,
    output logic [ADDR_W-1:0]      mem_addr
);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(N_INPUTS - 1);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_addr;

    always_comb w_addr = restart ? '0 : r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rd_en <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            r_ptr     <= '0;
        end else if (clear) begin
            mem_rd_en <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            r_ptr     <= '0;
        end else begin
            mem_rd_en <= issue;
            if (issue) begin
                mem_sel  <= bank;
                mem_addr <= w_addr;
                r_ptr    <= (w_addr == C_LAST) ? '0 : w_addr + 1'b1;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/ann_layer_sequencer.sv
// ============================================================================
// Module : ann_layer_sequencer
// Brief  : Fixed-schedule control FSM driving one ANN layer pass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ann_layer_sequencer
    import ann_pkg::*;
#(
    parameter int N_INPUTS  = 32,
    parameter int N_NEURONS = 10,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 5
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ann_seq_if.master  bus
);
    localparam int T_W   = $clog2(2*N_INPUTS + 8);
    localparam int C_OFS = 2*N_INPUTS + 1 - T_CHANGE;

    localparam logic [T_W-1:0] C_T_MAC_END  = T_W'(2*N_INPUTS);
    localparam logic [T_W-1:0] C_T_SRC_END  = T_W'(2*N_INPUTS - 1);
    localparam logic [T_W-1:0] C_T_ISS_END  = T_W'(2*N_INPUTS - 2);
    localparam logic [T_W-1:0] C_T_BIAS_L   = T_W'(T_BIAS_L + C_OFS);
    localparam logic [T_W-1:0] C_T_BIAS_H   = T_W'(T_BIAS_H + C_OFS);
    localparam logic [T_W-1:0] C_T_BADD     = T_W'(T_BADD + C_OFS);
    localparam logic [T_W-1:0] C_T_RELU     = T_W'(T_RELU + C_OFS);
    localparam logic [T_W-1:0] C_T_RSUM     = T_W'(T_RSUM + C_OFS);
    localparam logic [T_W-1:0] C_T_SLOT_END = T_W'(SLOT_LEN + C_OFS - 1);
    localparam logic [T_W-1:0] C_T_LOAD_END = T_W'(N_INPUTS - 1);
    localparam logic [3:0]     C_K_LAST     = 4'(N_NEURONS - 1);

    seq_state_t      r_state, w_nxt_state;
    logic [T_W-1:0]  r_t, w_nxt_t;
    logic [3:0]      r_k, w_nxt_k;
    ann_ctl_t        r_ctl, w_ctl;
    in_src_t         r_src, w_src;
    logic [DATA_W-1:0] r_in_last, w_in;
    logic            w_issue, w_restart;
    logic [3:0]      w_bank;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_t     = r_t + 1'b1;
        w_nxt_k     = r_k;
        case (r_state)
            S_IDLE: begin
                w_nxt_t = '0;
                w_nxt_k = '0;
                if (bus.start) w_nxt_state = S_PRE;
            end
            S_PRE: begin
                w_nxt_state = S_LOAD_IN;
                w_nxt_t     = '0;
            end
            S_LOAD_IN: if (r_t == C_T_LOAD_END) begin
                w_nxt_state = S_GAP;
                w_nxt_t     = '0;
            end
            S_GAP: begin
                w_nxt_state = S_NEURON;
                w_nxt_t     = '0;
                w_nxt_k     = '0;
            end
            S_NEURON: if (r_t == C_T_SLOT_END) begin
                w_nxt_t = '0;
                if (r_k == C_K_LAST) w_nxt_state = S_MAX;
                else                 w_nxt_k     = r_k + 4'd1;
            end
            S_MAX: begin
                w_nxt_state = S_DONE;
                w_nxt_t     = '0;
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_t     = '0;
                w_nxt_k     = '0;
            end
        endcase
        if (bus.abort) begin
            w_nxt_state = S_IDLE;
            w_nxt_t     = '0;
            w_nxt_k     = '0;
        end
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        w_ctl     = '0;
        w_src     = SRC_HOLD;
        w_issue   = 1'b0;
        w_restart = 1'b0;
        w_bank    = '0;
        case (w_nxt_state)
            S_PRE: begin
                w_ctl.busy = 1'b1;
                w_issue    = 1'b1;
                w_restart  = 1'b1;
                w_bank     = MEM_SEL_INPUT;
            end
            S_LOAD_IN: begin
                w_ctl.busy  = 1'b1;
                w_ctl.ld_in = 1'b1;
                w_src       = SRC_MEM;
                w_issue     = (w_nxt_t != C_T_LOAD_END);
                w_bank      = MEM_SEL_INPUT;
            end
            S_GAP: begin
                w_ctl.busy = 1'b1;
                w_issue    = 1'b1;
                w_restart  = 1'b1;
            end
            S_NEURON: begin
                w_ctl.busy   = 1'b1;
                w_ctl.neuron = w_nxt_k;
                w_bank       = w_nxt_k;
                if (w_nxt_t <= C_T_MAC_END) begin
                    w_ctl.ld_weight         = 1'b1;
                    w_ctl.ld_multiplication = 1'b1;
                    w_ctl.shift_in          = (w_nxt_t >= T_W'(2));
                end else begin
                    w_ctl.change = 1'b1;
                end
                if (!w_nxt_t[0] && w_nxt_t < C_T_SRC_END) w_src   = SRC_MEM;
                if (w_nxt_t[0] && w_nxt_t < C_T_ISS_END)  w_issue = 1'b1;
                if (w_nxt_t == C_T_BIAS_L) begin
                    w_ctl.ld_bias_lsb = 1'b1;
                    w_src             = SRC_BIAS_L;
                end
                if (w_nxt_t == C_T_BIAS_H) begin
                    w_ctl.ld_bias_msb = 1'b1;
                    w_src             = SRC_BIAS_H;
                end
                w_ctl.bias_addition = (w_nxt_t == C_T_BADD);
                w_ctl.relu          = (w_nxt_t == C_T_RELU);
                w_ctl.rst_sum       = (w_nxt_t == C_T_RSUM);
                // Last slot cycle prefetches weight 0 of the following neuron
                if (w_nxt_t == C_T_SLOT_END && w_nxt_k != C_K_LAST) begin
                    w_issue   = 1'b1;
                    w_restart = 1'b1;
                    w_bank    = w_nxt_k + 4'd1;
                end
            end
            S_MAX: begin
                w_ctl.busy        = 1'b1;
                w_ctl.ld_max_func = 1'b1;
            end
            S_DONE: begin
                w_ctl.busy = 1'b1;
                w_ctl.done = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_src)
            SRC_MEM:    w_in = bus.mem_rdata;
            SRC_BIAS_L: w_in = bus.bias_rdata[DATA_W-1:0];
            SRC_BIAS_H: w_in = bus.bias_rdata[2*DATA_W-1:DATA_W];
            default:    w_in = r_in_last;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_k       <= '0;
            r_ctl     <= '0;
            r_src     <= SRC_HOLD;
            r_in_last <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_t       <= w_nxt_t;
            r_k       <= w_nxt_k;
            r_ctl     <= w_ctl;
            r_src     <= w_src;
            r_in_last <= bus.abort ? '0 : w_in;
        end
    end

    ann_seq_addr_gen #(
        .N_INPUTS (N_INPUTS),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_nxt_state == S_IDLE),
        .issue     (w_issue),
        .restart   (w_restart),
        .bank      (w_bank),
        .mem_rd_en (bus.mem_rd_en),
        .mem_sel   (bus.mem_sel),
        .mem_addr  (bus.mem_addr)
    );

    assign bus.in                = w_in;
    assign bus.busy              = r_ctl.busy;
    assign bus.done              = r_ctl.done;
    assign bus.ld_in             = r_ctl.ld_in;
    assign bus.ld_weight         = r_ctl.ld_weight;
    assign bus.shift_in          = r_ctl.shift_in;
    assign bus.change            = r_ctl.change;
    assign bus.ld_multiplication = r_ctl.ld_multiplication;
    assign bus.ld_bias_LSB       = r_ctl.ld_bias_lsb;
    assign bus.ld_bias_MSB       = r_ctl.ld_bias_msb;
    assign bus.bias_addition     = r_ctl.bias_addition;
    assign bus.ReLU_computation  = r_ctl.relu;
    assign bus.rst_sum           = r_ctl.rst_sum;
    assign bus.ld_max_func       = r_ctl.ld_max_func;
    assign bus.ld_neuron         = r_ctl.neuron;
    assign bus.bias_addr         = r_ctl.neuron;
endmodule

`default_nettype wire

// File: tb/tb_ann_layer_sequencer.sv
// ============================================================================
// Module : tb_ann_layer_sequencer
// Brief  : Self-checking bench; per-cycle comparison against a schedule model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ann_layer_sequencer;
    localparam int NI    = 32;
    localparam int NN    = 10;
    localparam int SLOT  = 2*NI + 8;
    localparam int T0    = NI + 3;
    localparam int MAXC  = T0 + NN*SLOT;
    localparam int LASTC = MAXC + 2;

    typedef struct packed {
        logic       busy, done, ld_in, ld_weight, shift_in, change, ld_mult;
        logic       bl, bh, badd, relu, rsum, ldmax;
        logic [3:0] neuron, baddr;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic        drv;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_in = '0;

    logic [15:0] mem  [16][NI];
    logic [31:0] bias [16];

    ann_seq_if #(.DATA_W(16), .ADDR_W(5)) bus ();

    ann_layer_sequencer #(
        .N_INPUTS(NI), .N_NEURONS(NN), .DATA_W(16), .ADDR_W(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data one cycle after the request, junk otherwise
    always @(posedge clk)
        bus.mem_rdata <= bus.mem_rd_en ? mem[bus.mem_sel][bus.mem_addr] : 16'($urandom);

    assign bus.bias_rdata = bias[bus.bias_addr];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ctl_t got_ctl();
        ctl_t g;
        g = '{bus.busy, bus.done, bus.ld_in, bus.ld_weight, bus.shift_in, bus.change,
              bus.ld_multiplication, bus.ld_bias_LSB, bus.ld_bias_MSB, bus.bias_addition,
              bus.ReLU_computation, bus.rst_sum, bus.ld_max_func, bus.ld_neuron, bus.bias_addr};
        return g;
    endfunction

    // Expected outputs for cycle c of a pass, straight from the schedule
    function automatic exp_t model_at(int c);
        exp_t e;
        int   k, t, j;
        e = '0;
        if (c == 1) begin
            e.ctl.busy = 1'b1;
        end else if (c >= 2 && c <= NI + 1) begin
            e.ctl.busy = 1'b1; e.ctl.ld_in = 1'b1;
            e.drv = 1'b1; e.val = mem[15][c-2];
        end else if (c == NI + 2) begin
            e.ctl.busy = 1'b1;
        end else if (c >= T0 && c < MAXC) begin
            k = (c - T0) / SLOT;
            t = (c - T0) % SLOT;
            e.ctl.busy = 1'b1;
            e.ctl.neuron = 4'(k);
            e.ctl.baddr  = 4'(k);
            if (t <= 2*NI) begin
                e.ctl.ld_weight = 1'b1; e.ctl.ld_mult = 1'b1;
                e.ctl.shift_in  = (t >= 2);
                j = (t / 2 > NI - 1) ? NI - 1 : t / 2;
                e.drv = 1'b1; e.val = mem[k][j];
            end else begin
                e.ctl.change = 1'b1;
            end
            if (t == 2*NI + 2) begin e.ctl.bl = 1'b1; e.drv = 1'b1; e.val = bias[k][15:0];  end
            if (t == 2*NI + 3) begin e.ctl.bh = 1'b1; e.drv = 1'b1; e.val = bias[k][31:16]; end
            e.ctl.badd = (t == 2*NI + 4);
            e.ctl.relu = (t == 2*NI + 6);
            e.ctl.rsum = (t == 2*NI + 7);
        end else if (c == MAXC) begin
            e.ctl.busy = 1'b1; e.ctl.ldmax = 1'b1;
        end else if (c == MAXC + 1) begin
            e.ctl.busy = 1'b1; e.ctl.done = 1'b1;
        end
        return e;
    endfunction

    task automatic fill_random();
        for (int b = 0; b < 16; b++) begin
            for (int a = 0; a < NI; a++) mem[b][a] = 16'($urandom);
            bias[b] = $urandom;
        end
    endtask

    task automatic kick();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({got_ctl(), bus.in, bus.mem_rd_en, bus.mem_sel, bus.mem_addr} !== '0)
            begin n_fail++; $display("FAIL reset_state: got ctl=%h in=%h rd=%b, want all 0", got_ctl(), bus.in, bus.mem_rd_en); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        fill_random();
        exp_in = '0;
        kick();
        for (int c = 1; c <= 10; c++) begin
            e = model_at(c);
            if (e.drv) exp_in = e.val;
            n_checks++;
            if (got_ctl() !== e.ctl || bus.in !== exp_in)
                begin n_fail++; $display("FAIL pre_reset_cycle %0d: got ctl=%h in=%h want ctl=%h in=%h", c, got_ctl(), bus.in, e.ctl, exp_in); end
            if (c < 10) begin @(posedge clk); #1; end
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({got_ctl(), bus.in, bus.mem_rd_en, bus.mem_sel, bus.mem_addr} !== '0)
            begin n_fail++; $display("FAIL async_reset_mid_load: got ctl=%h in=%h rd=%b, want all 0", got_ctl(), bus.in, bus.mem_rd_en); end
        exp_in = '0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        kick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.mem_rd_en !== 1'b1 || bus.mem_sel !== 4'hF || bus.mem_addr !== 5'd0 || bus.ld_in !== 1'b0)
            begin n_fail++; $display("FAIL pre_cycle1: got busy=%b rd=%b sel=%h addr=%0d ld_in=%b want 1 1 f 0 0", bus.busy, bus.mem_rd_en, bus.mem_sel, bus.mem_addr, bus.ld_in); end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        exp_in = '0;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_in_pre: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_full_pass();
        exp_t e;
        int   dones;
        fill_random();
        for (int a = 0; a < NI; a++) begin
            mem[15][a] = 16'(a + 1);
            mem[3][a]  = 16'h0300 + 16'(a);
        end
        bias[0] = 32'hFFFB_5A00;
        dones = 0;
        kick();
        for (int c = 1; c <= LASTC + 3; c++) begin
            e = model_at(c);
            if (e.drv) exp_in = e.val;
            n_checks++;
            if (got_ctl() !== e.ctl || bus.in !== exp_in)
                begin n_fail++; $display("FAIL full_pass cycle %0d: got ctl=%h in=%h want ctl=%h in=%h", c, got_ctl(), bus.in, e.ctl, exp_in); end
            if (bus.done === 1'b1) dones++;
            if (c == 2 || c == 33) begin
                n_checks++;
                if (bus.in !== 16'(c - 1) || bus.ld_in !== 1'b1)
                    begin n_fail++; $display("FAIL ramp_in cycle %0d: got in=%h ld_in=%b want %h 1", c, bus.in, bus.ld_in, 16'(c - 1)); end
            end
            if (c == 34) begin
                n_checks++;
                if (bus.ld_in !== 1'b0) begin n_fail++; $display("FAIL ld_in_end: got %b want 0", bus.ld_in); end
            end
            if (c == T0 + 3*SLOT + 64) begin
                n_checks++;
                if (bus.in !== 16'h031F || bus.ld_weight !== 1'b1)
                    begin n_fail++; $display("FAIL bank3_last_hold: got in=%h ld_w=%b want 031f 1", bus.in, bus.ld_weight); end
            end
            if (c == T0 + 66) begin
                n_checks++;
                if (bus.in !== 16'h5A00 || bus.ld_bias_LSB !== 1'b1)
                    begin n_fail++; $display("FAIL bias_lsb: got in=%h strobe=%b want 5a00 1", bus.in, bus.ld_bias_LSB); end
            end
            if (c == T0 + 67) begin
                n_checks++;
                if (bus.in !== 16'hFFFB || bus.ld_bias_MSB !== 1'b1)
                    begin n_fail++; $display("FAIL bias_msb: got in=%h strobe=%b want fffb 1", bus.in, bus.ld_bias_MSB); end
            end
            if (c == 755) begin
                n_checks++;
                if (bus.ld_max_func !== 1'b1) begin n_fail++; $display("FAIL max_at_755: got %b want 1", bus.ld_max_func); end
            end
            bus.start = (c == 400);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        n_checks++;
        if (dones !== 1) begin n_fail++; $display("FAIL done_count: got %0d want 1", dones); end
    endtask

    task automatic test_abort();
        exp_t e;
        fill_random();
        kick();
        for (int c = 1; c <= 500; c++) begin
            e = model_at(c);
            if (e.drv) exp_in = e.val;
            n_checks++;
            if (got_ctl() !== e.ctl || bus.in !== exp_in)
                begin n_fail++; $display("FAIL pre_abort cycle %0d: got ctl=%h in=%h want ctl=%h in=%h", c, got_ctl(), bus.in, e.ctl, exp_in); end
            if (c < 500) begin @(posedge clk); #1; end
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        exp_in = '0;
        n_checks++;
        if (got_ctl() !== '0 || bus.in !== 16'h0 || bus.mem_rd_en !== 1'b0)
            begin n_fail++; $display("FAIL abort_501: got ctl=%h in=%h rd=%b want all 0", got_ctl(), bus.in, bus.mem_rd_en); end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0)
                begin n_fail++; $display("FAIL post_abort_idle %0d: got done=%b busy=%b want 0 0", c, bus.done, bus.busy); end
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0)
                begin n_fail++; $display("FAIL abort_with_start %0d: got busy=%b rd=%b want 0 0", c, bus.busy, bus.mem_rd_en); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            fill_random();
            kick();
            for (int c = 1; c <= LASTC; c++) begin
                e = model_at(c);
                if (e.drv) exp_in = e.val;
                n_checks++;
                if (got_ctl() !== e.ctl || bus.in !== exp_in)
                    begin n_fail++; $display("FAIL pass%0d cycle %0d: got ctl=%h in=%h want ctl=%h in=%h", p, c, got_ctl(), bus.in, e.ctl, exp_in); end
                if (c < LASTC) begin @(posedge clk); #1; end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_full_pass();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
